// File: rtl/mem_io_pkg.sv
// mem_io_pkg: shared state encoding and constants for the SLC-3 memory responder
package mem_io_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, DONE, RELEASE} mem_state_t;
  localparam logic [15:0] IO_ADDR = 16'hFFFF;
  localparam int WS_W = 4;
endpackage

// File: rtl/mem2io_responder.sv
// mem2io_responder: services SLC-3 memory requests against async SRAM with wait states, maps 0xFFFF to switches/hex display
module mem2io_responder
  import mem_io_pkg::*;
#(
  parameter int WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        MIO_EN,
  input  logic        WE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  input  logic [15:0] SW,
  output logic [15:0] Data_to_CPU,
  output logic        R,
  output logic [15:0] HEX_Data,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_wdata,
  input  logic [15:0] sram_rdata,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);
  mem_state_t state_q, state_d;
  logic [WS_W-1:0] cnt_q, cnt_d;
  logic we_q, we_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d, hex_q, hex_d;
  logic r_q, r_d, ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic io, sram_act;
  assign io = addr_q == IO_ADDR;
  assign sram_act = (state_q == SETUP && !io) || state_q == ACCESS;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    data_d = data_q;
    hex_d = hex_q;
    r_d = state_q == DONE;
    ce_n_d = !sram_act;
    oe_n_d = !(sram_act && !we_q);
    we_n_d = !(state_q == ACCESS && we_q);
    case (state_q)
      IDLE: if (MIO_EN) begin
        state_d = SETUP;
        we_d = WE;
        addr_d = MAR;
        wdata_d = MDR;
      end
      SETUP: if (io) begin
        state_d = DONE;
        hex_d = we_q ? wdata_q : hex_q;
        data_d = we_q ? data_q : SW;
      end else begin
        state_d = ACCESS;
        cnt_d = WS_W'(WAIT_STATES - 1);
      end
      ACCESS: if (cnt_q == '0) begin
        state_d = DONE;
        data_d = we_q ? data_q : sram_rdata;
      end else cnt_d = cnt_q - 1'b1;
      DONE: state_d = MIO_EN ? RELEASE : IDLE;
      RELEASE: state_d = MIO_EN ? RELEASE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      data_q <= '0;
      hex_q <= '0;
      r_q <= 1'b0;
      ce_n_q <= 1'b1;
      oe_n_q <= 1'b1;
      we_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      data_q <= data_d;
      hex_q <= hex_d;
      r_q <= r_d;
      ce_n_q <= ce_n_d;
      oe_n_q <= oe_n_d;
      we_n_q <= we_n_d;
    end
  end
  assign Data_to_CPU = data_q;
  assign R = r_q;
  assign HEX_Data = hex_q;
  assign sram_addr = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
endmodule

// File: tb/tb_mem2io_responder.sv
// tb_mem2io_responder: directed self-checking bench for the SLC-3 memory responder
module tb_mem2io_responder;
  import mem_io_pkg::*;
  logic Clk, Reset_n, MIO_EN, WE, R, sram_ce_n, sram_oe_n, sram_we_n;
  logic [15:0] MAR, MDR, SW, Data_to_CPU, HEX_Data, sram_addr, sram_wdata, sram_rdata;
  logic [15:0] mem [0:65535];
  int checks = 0;
  int failures = 0;
  mem2io_responder #(.WAIT_STATES(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .MIO_EN(MIO_EN), .WE(WE), .MAR(MAR), .MDR(MDR), .SW(SW),
    .Data_to_CPU(Data_to_CPU), .R(R), .HEX_Data(HEX_Data), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;
  always @(posedge Clk) if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_wdata;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // drives one request at a negedge; sample index k = cycle after edge k
  task automatic run(input logic we_i, input logic [15:0] a, input logic [15:0] d, input int hold,
                     input int n, output int r_edge, output int r_cnt, output logic [15:0] r_data,
                     output int ce_cnt, output int oe_cnt, output int we_cnt, output logic addr_ok,
                     output logic saw_rel);
    MIO_EN = 1'b1; WE = we_i; MAR = a; MDR = d;
    r_edge = -1; r_cnt = 0; r_data = 16'h0; ce_cnt = 0; oe_cnt = 0; we_cnt = 0;
    addr_ok = 1'b1; saw_rel = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge Clk);
      if (R) begin
        r_cnt++;
        if (r_edge < 0) begin r_edge = k; r_data = Data_to_CPU; end
      end
      if (!sram_ce_n) ce_cnt++;
      if (!sram_oe_n) oe_cnt++;
      if (!sram_we_n) begin
        we_cnt++;
        if (sram_addr !== a || sram_wdata !== d) addr_ok = 1'b0;
      end
      if (dut.state_q == RELEASE) saw_rel = 1'b1;
      MAR = ~a; MDR = ~d; WE = ~we_i;
      if (k + 1 >= hold) MIO_EN = 1'b0;
    end
  endtask
  int re, rc, cc, oc, wc, rcount;
  logic [15:0] rd;
  logic aok, srel;
  initial begin
    Reset_n = 1'b0; MIO_EN = 1'b0; WE = 1'b0; MAR = 16'h0; MDR = 16'h0; SW = 16'h0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    rcount = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (R || !sram_ce_n || !sram_oe_n || !sram_we_n) rcount++;
    end
    check("rst_data", Data_to_CPU, 0);
    check("rst_hex", HEX_Data, 0);
    check("rst_r", R, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_wdata", sram_wdata, 0);
    check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    check("rst_activity", rcount, 0);
    run(1'b1, 16'h3000, 16'hBEEF, 5, 8, re, rc, rd, cc, oc, wc, aok, srel);
    check("wr_r_edge", re, 4);
    check("wr_r_cnt", rc, 1);
    check("wr_we_cycles", wc, 2);
    check("wr_ce_cycles", cc, 3);
    check("wr_oe_cycles", oc, 0);
    check("wr_addr_data", aok, 1);
    check("wr_data_held", Data_to_CPU, 0);
    run(1'b0, 16'h3000, 16'h0000, 8, 11, re, rc, rd, cc, oc, wc, aok, srel);
    check("rd_r_edge", re, 4);
    check("rd_r_cnt", rc, 1);
    check("rd_data", rd, 16'hBEEF);
    check("rd_ce_cycles", cc, 3);
    check("rd_oe_cycles", oc, 3);
    check("rd_we_cycles", wc, 0);
    check("rd_release", srel, 1);
    check("rd_state_end", 32'(dut.state_q), 32'(IDLE));
    run(1'b1, 16'hFFFF, 16'h1234, 3, 6, re, rc, rd, cc, oc, wc, aok, srel);
    check("iow_r_edge", re, 2);
    check("iow_r_cnt", rc, 1);
    check("iow_strobes", cc + oc + wc, 0);
    check("iow_hex", HEX_Data, 16'h1234);
    check("iow_data_held", Data_to_CPU, 16'hBEEF);
    SW = 16'h00A5;
    run(1'b0, 16'hFFFF, 16'h0000, 3, 6, re, rc, rd, cc, oc, wc, aok, srel);
    check("ior_r_edge", re, 2);
    check("ior_data", rd, 16'h00A5);
    check("ior_strobes", cc + oc + wc, 0);
    check("ior_hex_held", HEX_Data, 16'h1234);
    run(1'b1, 16'h3001, 16'h5A5A, 5, 8, re, rc, rd, cc, oc, wc, aok, srel);
    check("wr2_r_edge", re, 4);
    run(1'b0, 16'h3001, 16'h0000, 1, 8, re, rc, rd, cc, oc, wc, aok, srel);
    check("drop_r_edge", re, 4);
    check("drop_r_cnt", rc, 1);
    check("drop_data", rd, 16'h5A5A);
    check("drop_no_release", srel, 0);
    check("drop_state_end", 32'(dut.state_q), 32'(IDLE));
    MIO_EN = 1'b1; WE = 1'b1; MAR = 16'h3002; MDR = 16'h7777;
    repeat (3) @(negedge Clk);
    check("arst_pre_we", sram_we_n, 0);
    #2 Reset_n = 1'b0;
    #1;
    check("arst_we", sram_we_n, 1);
    check("arst_ce", sram_ce_n, 1);
    check("arst_r", R, 0);
    MIO_EN = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    rcount = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (R) rcount++;
    end
    check("arst_no_r", rcount, 0);
    check("arst_state", 32'(dut.state_q), 32'(IDLE));
    check("arst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem2io_responder.md
# mem2io_responder

Memory-side responder for the SLC-3 CPU's memory interface. It accepts the CPU's level-held memory requests (MIO_EN, write enable, MAR, MDR) and services them against an asynchronous SRAM with programmable wait states. It decodes address 0xFFFF as memory-mapped I/O: reads return the switches, writes load the hex display register. It returns read data as Data_to_CPU and signals completion with a one-cycle ready pulse R, on which the CPU control FSM advances.

## Interface
Parameters:
- WAIT_STATES, 2: SRAM access cycles with strobe asserted; legal range 1..15.

Ports:
- Clk  in  1  system clock; all state changes on its rising edge.
- Reset_n  in  1  reset, asynchronous, active-low.
- MIO_EN  in  1  request valid; held high by the CPU for the whole memory state.
- WE  in  1  1 = write, 0 = read; valid while MIO_EN is high.
- MAR  in  16  request address.
- MDR  in  16  write data.
- SW  in  16  switch inputs.
- Data_to_CPU  out  16  read data, registered.
- R  out  1  ready; one-cycle pulse per completed request.
- HEX_Data  out  16  display register.
- sram_addr  out  16  SRAM address, registered.
- sram_wdata  out  16  SRAM write data, registered.
- sram_rdata  in  16  SRAM read data.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active-low, registered.

## Operation
- States: IDLE, SETUP, ACCESS, DONE, RELEASE.
- IDLE, MIO_EN = 1:
  - Latch MAR, MDR and WE.
  - Load sram_addr and sram_wdata from the latched values.
  - Go to SETUP.
- IDLE, MIO_EN = 0: stay in IDLE.
- SETUP, SRAM path (latched address != 0xFFFF):
  - sram_ce_n = 0.
  - For a read, sram_oe_n = 0.
  - Load the wait counter with WAIT_STATES-1.
  - Go to ACCESS.
- SETUP, I/O path (latched address = 0xFFFF):
  - No SRAM strobe asserts.
  - Read: Data_to_CPU <= SW.
  - Write: HEX_Data <= latched MDR.
  - Go to DONE.
- ACCESS:
  - sram_ce_n = 0.
  - Read: sram_oe_n = 0. Write: sram_we_n = 0.
  - Counter decrements each cycle.
  - When the counter reaches 0, a read captures sram_rdata into Data_to_CPU, and the state goes to DONE.
- DONE:
  - All strobes deasserted (high); R = 1 for exactly one cycle.
  - Next state is RELEASE if MIO_EN = 1, else IDLE.
- RELEASE: wait for MIO_EN = 0, then go to IDLE. This prevents a held request from being serviced twice.
- MIO_EN falling mid-transaction does not abort it. The transaction completes, R still pulses, and DONE goes to IDLE.
- Changes on MAR, MDR or WE after IDLE latches them are ignored until the next request.
- Data_to_CPU holds its value until the next read completes. Writes never change it.
- HEX_Data changes only on an I/O write.
- sram_addr and sram_wdata hold between requests.

## Timing
- Reset values:
  - Data_to_CPU = 0, HEX_Data = 0, R = 0.
  - sram_addr = 0, sram_wdata = 0.
  - sram_ce_n = sram_oe_n = sram_we_n = 1.
  - State = IDLE.
- Reset assertion is asynchronous: strobes deassert and R clears immediately, even mid-ACCESS.
- Reset release takes effect on the next Clk edge.
- Latency is counted from the edge that samples MIO_EN = 1 in IDLE (edge 0):
  - SRAM request: R high during the cycle after edge 2+WAIT_STATES (WAIT_STATES=2 gives edge 4).
  - I/O request: R high after edge 2.
- Read data is valid on Data_to_CPU in the same cycle R is high.
- Write: sram_addr and sram_wdata are stable one cycle before sram_we_n falls and at least one cycle after it rises.
- Back-to-back requests: a new request needs MIO_EN low for at least one cycle after R. The minimum request spacing is latency+1 cycles.

## Structure
- Shared package mem_io_pkg holds:
  - the state enum mem_state_t {IDLE, SETUP, ACCESS, DONE, RELEASE};
  - the constant IO_ADDR = 16'hFFFF;
  - the constant WS_W = 4 (wait counter width).
- Single module with the FSM, wait counter, request latches and I/O registers inline. No sub-module is natural at this size.

## Test plan
- Reset_n low, then released with MIO_EN = 0 -> all outputs at reset values; the state stays IDLE, with no strobe and no R.
- Write MAR=0x3000, MDR=0xBEEF, WAIT_STATES=2 -> sram_we_n low for exactly 2 cycles with sram_addr=0x3000, sram_wdata=0xBEEF; R pulses once at edge 4.
- Read MAR=0x3000 with the SRAM model returning 0xBEEF -> Data_to_CPU=0xBEEF when R pulses at edge 4; MIO_EN held 3 extra cycles -> no second access and no second R.
- I/O write MAR=0xFFFF, MDR=0x1234, then I/O read with SW=0x00A5 -> HEX_Data=0x1234 and Data_to_CPU=0x00A5; each R at edge 2; no SRAM strobe ever asserts.
- Reset_n pulsed low during ACCESS of a write -> sram_we_n and sram_ce_n go high in the same cycle with no Clk edge; the state is IDLE after release, and no R is produced.
- MIO_EN dropped one cycle after the read request -> the read still completes, R pulses at edge 2+WAIT_STATES, and the state returns to IDLE without entering RELEASE.
